uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte FIFO plus transmit sequencer that sits directly upstream of the UART transmitter. It turns a multi-byte stream into back-to-back 8N1 frames.
- The producer (CPU bus / test driver) pushes bytes with a simple write strobe.
- The sequencer pops one byte at a time, presents it on tx_byte, strobes the transmitter's active-low tx_en for exactly one cycle, then waits for the transmitter's one-cycle tx_complete pulse before sending the next byte.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- GAP_CYCLES, 0: idle sourceClk cycles inserted after each tx_complete before the next strobe; 0 means no gap.

Ports:
- sourceClk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge sourceClk).
- wr_en  input  1  push wr_data this cycle (active high).
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when wr_en is seen while full.
- tx_en  output  1  to transmitter; active low; low for exactly one cycle per byte.
- tx_byte  output  8  to transmitter; stable from the strobe cycle until tx_complete.
- tx_complete  input  1  from transmitter; one-cycle pulse, frame finished.
- busy  output  1  high while a byte is in flight (SqStrobe, SqWait, SqGap).
- byte_sent  output  1  one-cycle pulse, registered copy of an accepted tx_complete.

Behaviour:
- All state is updated on posedge sourceClk. The clock domain and reset are shared with the transmitter.
- Reset (reset==0), all registered, values seen on the cycle after the reset edge:
  - tx_en=1, tx_byte=0, busy=0, byte_sent=0, overflow=0.
  - rd_ptr=wr_ptr=0, count=0, empty=1, full=0.
  - state=SqReset. FIFO storage is not cleared.
- Reset mid-operation discards the FIFO contents and the in-flight byte. A tx_complete arriving afterwards, outside SqWait, is ignored.
- FIFO:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count, full and empty are registers derived from count.
  - Write accepted when wr_en && !full: mem[wr_ptr]<=wr_data, wr_ptr++.
  - Write while full is dropped with no state change and overflow=1 for one cycle.
  - Pop happens only in the sequencer's SqIdle->SqStrobe transition.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance. Legal when full, because the pop frees a slot in the same edge.
  - Pop decision uses registered empty, so there is no read-during-write bypass.
- State machine:
  - SqReset: next state SqIdle (covers the transmitter's own one-cycle TxReset).
  - SqIdle: if !empty, on the edge tx_byte<=mem[rd_ptr], rd_ptr++, count--, tx_en<=0, busy<=1, state<=SqStrobe.
  - SqStrobe: tx_en<=1, state<=SqWait. The transmitter samples tx_en low at this edge.
  - SqWait: holds tx_byte. On tx_complete: byte_sent<=1; if GAP_CYCLES==0, state<=SqIdle and busy<=0; otherwise load gap counter=GAP_CYCLES-1 and go to SqGap.
  - SqGap: decrement the counter; at 0, state<=SqIdle and busy<=0.
- Latency:
  - A byte written at edge N into an empty FIFO in SqIdle: tx_en is low from edge N+1 to N+2.
  - With GAP_CYCLES=0, tx_complete at edge M puts the next tx_en low from edge M+1 to M+2.
- Illegal or ignored inputs: tx_complete outside SqWait is ignored. Undefined state encodings go to SqIdle.

Test Plan:
- Single byte: after reset, write 0xA5 → empty=0 for one cycle, tx_en low exactly one cycle at N+1, tx_byte=0xA5 held. Transmitter line shows start bit, 1,0,1,0,0,1,0,1, stop. byte_sent pulses once, busy falls, count=0.
- Burst fill: write 0x00..0x0F back-to-back (DEPTH=16) while the first byte is in flight → full=1 at count 16. A 17th write gives overflow=1 for one cycle and count stays 16. Line output is 0x00..0x0F in order with no lost or duplicated bytes.
- Full + pop same edge: with count=16 in SqIdle, assert wr_en=0x55 on the pop edge → count stays 16, full stays 1, no overflow, and 0x55 is transmitted last.
- Gap timing: GAP_CYCLES=10, two bytes queued → the second tx_en falls exactly 11 cycles after the first tx_complete edge.
- Reset mid-operation: reset=0 for one cycle during SqWait with 5 bytes queued → count=0, empty=1, tx_en=1. The late tx_complete is ignored (no byte_sent), and no further strobes occur until a new write.
- Spurious tx_complete pulsed in SqIdle with the FIFO empty → no state change, byte_sent=0.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and sequencer feeding an 8N1 transmitter one byte at a time
// Strobes active-low tx_en for one cycle per byte and waits for tx_complete before the next.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     sourceClk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx_en,
  output logic [7:0]               tx_byte,
  input  logic                     tx_complete,
  output logic                     busy,
  output logic                     byte_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  typedef enum logic [2:0] {
    SQ_RESET  = 3'd0,
    SQ_IDLE   = 3'd1,
    SQ_STROBE = 3'd2,
    SQ_WAIT   = 3'd3,
    SQ_GAP    = 3'd4
  } sq_state_e;

  sq_state_e         state_q, state_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;
  logic              byte_sent_q, byte_sent_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              push;
  logic              pop;
  logic [7:0]        mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    tx_en_d     = tx_en_q;
    tx_byte_d   = tx_byte_q;
    busy_d      = busy_q;
    gap_cnt_d   = gap_cnt_q;
    byte_sent_d = 1'b0;
    pop         = 1'b0;

    case (state_q)
      SQ_RESET: state_d = SQ_IDLE;
      SQ_IDLE: begin
        // Registered empty only: a byte written this edge is popped next edge.
        if (!empty_q) begin
          pop       = 1'b1;
          tx_byte_d = mem[rd_ptr_q];
          tx_en_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = SQ_STROBE;
        end
      end
      SQ_STROBE: begin
        tx_en_d = 1'b1;
        state_d = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (tx_complete) begin
          byte_sent_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = SQ_IDLE;
            busy_d  = 1'b0;
          end else begin
            gap_cnt_d = GW'(GAP_CYCLES - 1);
            state_d   = SQ_GAP;
          end
        end
      end
      SQ_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = SQ_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = SQ_IDLE;
        tx_en_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A pop on the same edge frees a slot, so a write while full is still taken.
    push       = wr_en && (!full_q || pop);
    overflow_d = wr_en && full_q && !pop;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      state_q     <= SQ_RESET;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      tx_en_q     <= 1'b1;
      tx_byte_q   <= 8'h00;
      busy_q      <= 1'b0;
      byte_sent_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      tx_en_q     <= tx_en_d;
      tx_byte_q   <= tx_byte_d;
      busy_q      <= busy_d;
      byte_sent_q <= byte_sent_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_ff @(posedge sourceClk) begin
    if (reset && push) mem[wr_ptr_q] <= wr_data;
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_en     = tx_en_q;
  assign tx_byte   = tx_byte_q;
  assign busy      = busy_q;
  assign byte_sent = byte_sent_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder
module tb_uart_tx_feeder;

  logic       sourceClk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_en, busy, byte_sent;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       tx_complete;
  logic       resp_pulse;
  logic       man_pulse;

  logic       g_wr_en;
  logic [7:0] g_wr_data;
  logic       g_full, g_empty, g_overflow, g_tx_en, g_busy, g_byte_sent;
  logic [4:0] g_count;
  logic [7:0] g_tx_byte;
  logic       g_man;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_sent  = 0;
  int         n_strobe = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_b;
  logic [7:0] held;
  bit         prev_low;
  bit         inflight;
  bit         auto_resp;
  int         frame_len;
  int         frame_cnt;

  assign tx_complete = resp_pulse | man_pulse;

  uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(0)) dut (
    .sourceClk   (sourceClk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .tx_en       (tx_en),
    .tx_byte     (tx_byte),
    .tx_complete (tx_complete),
    .busy        (busy),
    .byte_sent   (byte_sent)
  );

  uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(10)) dut_gap (
    .sourceClk   (sourceClk),
    .reset       (reset),
    .wr_en       (g_wr_en),
    .wr_data     (g_wr_data),
    .full        (g_full),
    .empty       (g_empty),
    .count       (g_count),
    .overflow    (g_overflow),
    .tx_en       (g_tx_en),
    .tx_byte     (g_tx_byte),
    .tx_complete (g_man),
    .busy        (g_busy),
    .byte_sent   (g_byte_sent)
  );

  initial sourceClk = 1'b0;
  always #5 sourceClk = ~sourceClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor + scoreboard + simple transmitter model, sampled 1 time unit after each edge.
  always @(posedge sourceClk) begin
    #1;
    resp_pulse = 1'b0;
    if (byte_sent) begin
      n_sent++;
      inflight = 1'b0;
    end
    if (!reset) begin
      inflight = 1'b0;
      prev_low = 1'b0;
    end else begin
      if (prev_low) begin
        check("strobe_width", tx_en, 1);
        check("byte_hold", tx_byte, held);
      end
      if (!tx_en) begin
        n_strobe++;
        if (sb.size() == 0) begin
          check("sb_has_entry", 0, 1);
        end else begin
          exp_b = sb.pop_front();
          check("tx_byte", tx_byte, exp_b);
        end
        held      = tx_byte;
        inflight  = 1'b1;
        frame_cnt = frame_len;
      end else if (auto_resp && inflight) begin
        if (frame_cnt == 0) begin
          resp_pulse = 1'b1;
          inflight   = 1'b0;
        end else begin
          frame_cnt--;
        end
      end
      prev_low = !tx_en;
    end
  end

  task automatic wr(input logic [7:0] b, input bit accept);
    @(negedge sourceClk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) sb.push_back(b);
  endtask

  task automatic wr_idle();
    @(negedge sourceClk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_complete();
    @(negedge sourceClk);
    man_pulse = 1'b1;
    @(negedge sourceClk);
    man_pulse = 1'b0;
  endtask

  task automatic wait_sent(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_sent < target && k < budget) begin
      @(posedge sourceClk);
      #2;
      k++;
    end
    check(tag, (n_sent >= target), 1);
  endtask

  initial begin
    int n0;
    int s0;
    int k;
    reset      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    man_pulse  = 1'b0;
    resp_pulse = 1'b0;
    g_wr_en    = 1'b0;
    g_wr_data  = 8'h00;
    g_man      = 1'b0;
    auto_resp  = 1'b0;
    frame_len  = 12;
    prev_low   = 1'b0;
    inflight   = 1'b0;

    repeat (2) @(posedge sourceClk);
    #1;
    check("rst_tx_en", tx_en, 1);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_byte_sent", byte_sent, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    @(negedge sourceClk);
    reset = 1'b1;

    // Single byte latency
    auto_resp = 1'b1;
    wr(8'hA5, 1);
    @(posedge sourceClk);
    #1;
    check("single_empty_n", empty, 0);
    check("single_count_n", count, 1);
    check("single_tx_en_n", tx_en, 1);
    wr_idle();
    @(posedge sourceClk);
    #1;
    check("single_tx_en_n1", tx_en, 0);
    check("single_empty_n1", empty, 1);
    check("single_busy_n1", busy, 1);
    wait_sent("single_sent", 1, 100);
    @(negedge sourceClk);
    check("single_busy_end", busy, 0);
    check("single_count_end", count, 0);
    check("single_tx_en_end", tx_en, 1);

    // Burst fill behind an in-flight byte, then overflow
    auto_resp = 1'b0;
    wr(8'hEE, 1);
    wr_idle();
    @(negedge sourceClk);
    for (int i = 0; i < 16; i++) wr(8'(i), 1);
    @(posedge sourceClk);
    #1;
    check("burst_count16", count, 16);
    check("burst_full", full, 1);
    check("burst_no_ovf", overflow, 0);
    wr(8'h99, 0);
    @(posedge sourceClk);
    #1;
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 16);
    wr_idle();
    @(posedge sourceClk);
    #1;
    check("ovf_clear", overflow, 0);

    // Full plus pop on the same edge
    @(negedge sourceClk);
    man_pulse = 1'b1;
    @(negedge sourceClk);
    man_pulse = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'h55;
    sb.push_back(8'h55);
    @(posedge sourceClk);
    #1;
    check("fullpop_count", count, 16);
    check("fullpop_full", full, 1);
    check("fullpop_no_ovf", overflow, 0);
    check("fullpop_strobe", tx_en, 0);
    wr_idle();
    auto_resp = 1'b1;
    wait_sent("burst_drain", 19, 1500);
    @(negedge sourceClk);
    check("burst_sb_empty", sb.size(), 0);
    check("burst_fifo_empty", empty, 1);

    // Spurious tx_complete while idle and empty
    auto_resp = 1'b0;
    n0 = n_sent;
    pulse_complete();
    repeat (3) @(negedge sourceClk);
    check("spur_no_sent", n_sent, n0);
    check("spur_busy", busy, 0);
    check("spur_tx_en", tx_en, 1);

    // Reset during SqWait with 5 bytes queued
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i), 1);
    wr_idle();
    repeat (2) @(negedge sourceClk);
    check("mid_count5", count, 5);
    check("mid_busy", busy, 1);
    reset = 1'b0;
    @(negedge sourceClk);
    reset = 1'b1;
    sb.delete();
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_tx_en", tx_en, 1);
    check("mid_rst_busy", busy, 0);
    n0 = n_sent;
    s0 = n_strobe;
    pulse_complete();
    repeat (20) @(negedge sourceClk);
    check("mid_late_ignored", n_sent, n0);
    check("mid_no_strobe", n_strobe, s0);
    auto_resp = 1'b1;
    wr(8'h3C, 1);
    wr_idle();
    wait_sent("mid_restart", n0 + 1, 100);
    check("mid_sb_empty", sb.size(), 0);

    // Gap timing on the GAP_CYCLES=10 instance
    @(negedge sourceClk);
    g_wr_en   = 1'b1;
    g_wr_data = 8'h81;
    @(negedge sourceClk);
    g_wr_data = 8'h42;
    @(negedge sourceClk);
    g_wr_en   = 1'b0;
    check("gap_first_strobe", g_tx_en, 0);
    check("gap_first_byte", g_tx_byte, 8'h81);
    repeat (5) @(negedge sourceClk);
    g_man = 1'b1;
    @(negedge sourceClk);
    g_man = 1'b0;
    k = 0;
    while (k <= 30) begin
      @(posedge sourceClk);
      k++;
      #1;
      if (!g_tx_en) break;
    end
    check("gap_cycles", k, 11);
    check("gap_second_byte", g_tx_byte, 8'h42);
    @(negedge sourceClk);
    check("gap_count", g_count, 0);
    check("gap_empty", g_empty, 1);
    check("gap_full", g_full, 0);
    check("gap_ovf", g_overflow, 0);
    check("gap_busy", g_busy, 1);
    check("gap_byte_sent", g_byte_sent, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
